gp9001_host_if: RTL
===================

Name: gp9001_host_if

Overview:
- Responder end of the 68k→GP9001 command interface.
- Consumes the level-held operation requests raised by the main-CPU block: OP_SELECT_REG, OP_WRITE_REG, OP_WRITE_RAM, OP_READ_RAM_H, OP_READ_RAM_L, OP_SET_RAM_PTR.
- Executes each request against the VRAM host port and the register-write bus, then returns GP9001ACK using a 4-phase handshake.
- Sits inside the GP9001 video block, between the CPU bus and the VRAM/scroll-register logic.

Parameters:
- AW, 14, VRAM word-address width; pointer wraps modulo 2^AW.
- RDLAT, 1, VRAM read latency in cycles from VRAM_RD to valid VRAM_Q; legal range 1..3.

Ports:
- CLK96  in  1  system clock; single clock domain.
- RESET96n  in  1  asynchronous active-low reset.
- OP_SELECT_REG  in  1  request: latch register index.
- OP_WRITE_REG  in  1  request: write selected register.
- OP_WRITE_RAM  in  1  request: write VRAM at pointer.
- OP_READ_RAM_H  in  1  request: read VRAM at pointer.
- OP_READ_RAM_L  in  1  request: read VRAM at pointer.
- OP_SET_RAM_PTR  in  1  request: load VRAM pointer.
- DIN  in  16  CPU write data, stable while any request is high.
- ACK  out  1  GP9001ACK to the initiator.
- DOUT  out  16  GP9001_DOUT read data.
- VRAM_ADDR  out  AW  host-port address.
- VRAM_DIN  out  16  host-port write data.
- VRAM_WE  out  1  one-cycle write strobe.
- VRAM_RD  out  1  one-cycle read strobe.
- VRAM_Q  in  16  host-port read data.
- VRAM_GNT  in  1  host port may be used this cycle; renderer owns the port when low.
- REG_WE  out  1  one-cycle register-write strobe.
- REG_ADDR  out  8  selected register index.
- REG_DATA  out  16  register write data.
- RAM_PTR  out  AW  current pointer, for debug and readback.

Behaviour:
- Reset (async, RESET96n low):
  - ACK=0, DOUT=0, VRAM_WE=0, VRAM_RD=0, REG_WE=0.
  - VRAM_ADDR=0, VRAM_DIN=0, REG_ADDR=0, REG_DATA=0, RAM_PTR=0.
  - FSM=IDLE.
  - Reset mid-operation aborts the operation; no strobe is issued after deassertion until a new request arrives.
- Request decode, sampled only in IDLE:
  - When several requests are high, exactly one is served, chosen by priority: SET_RAM_PTR > SELECT_REG > WRITE_REG > WRITE_RAM > READ_RAM_H > READ_RAM_L.
  - The others are ignored for this handshake.
- FSM states: IDLE, RAMWAIT, RDWAIT, DONE.
  - IDLE, SET_RAM_PTR: RAM_PTR <= DIN[AW-1:0]; go to DONE.
  - IDLE, SELECT_REG: REG_ADDR <= DIN[7:0]; go to DONE.
  - IDLE, WRITE_REG: REG_DATA <= DIN; REG_WE pulses for 1 cycle with the current REG_ADDR; go to DONE.
  - IDLE, WRITE_RAM or READ_RAM_*: go to RAMWAIT.
  - RAMWAIT: stay while VRAM_GNT=0.
  - RAMWAIT, VRAM_GNT=1, write: VRAM_ADDR <= RAM_PTR, VRAM_DIN <= DIN, one-cycle VRAM_WE, RAM_PTR <= RAM_PTR+1 (wraps); go to DONE.
  - RAMWAIT, VRAM_GNT=1, read: VRAM_ADDR <= RAM_PTR, one-cycle VRAM_RD; go to RDWAIT.
  - RDWAIT: count RDLAT cycles, then DOUT <= VRAM_Q, RAM_PTR <= RAM_PTR+1; go to DONE. READ_RAM_H and READ_RAM_L behave identically.
  - DONE: ACK=1, registered. Stay while any OP_* input is high. When all are low: ACK <= 0, go to IDLE.
- ACK rises no earlier than 1 cycle after the request is seen.
  - Latency, register ops: 2 cycles from request to ACK.
  - Latency, RAM write with GNT=1: 3 cycles.
  - Latency, RAM read: 3+RDLAT cycles.
- ACK never rises while VRAM_WE or VRAM_RD is asserted in the same cycle.
- DOUT holds its last read value until the next completed read; writes never modify it.
- Pointer wrap: RAM_PTR = 2^AW-1 followed by an access gives RAM_PTR = 0.
- If VRAM_GNT drops in RDWAIT, the read still completes; the grant is checked only at issue.
- A request that deasserts before service while still in IDLE is dropped silently.
- A new request arriving while in DONE is not served until after ACK falls and the FSM returns to IDLE.

Decomposition:
- Shared package gp9001_pkg:
  - FSM state enum.
  - Op-code enum: OP_PTR, OP_SEL, OP_WREG, OP_WRAM, OP_RD.
  - Priority-encode function.
  - Constant GP9001_REG_W = 8.
- No sub-module required. The RDLAT delay counter stays inline.

Test Plan:
1. Pointer and write. Sequence: SET_RAM_PTR with DIN=0x1234, ACK, drop; then WRITE_RAM with DIN=0xBEEF, VRAM_GNT=1. Required: VRAM_WE pulse with VRAM_ADDR=0x1234 and VRAM_DIN=0xBEEF; RAM_PTR=0x1235; ACK held until the request drops, then ACK=0 one cycle later.
2. Register path. SELECT_REG with DIN=0x008F, then WRITE_REG with DIN=0x0140. Required: exactly one REG_WE pulse with REG_ADDR=0x8F and REG_DATA=0x0140; no VRAM strobes.
3. Read with latency. Set RDLAT=2, pointer 0x3FFF, VRAM_Q model returns 0xA5A5, issue READ_RAM_L. Required: DOUT=0xA5A5 when ACK rises, ACK at cycle 5 after the request, RAM_PTR wraps to 0x0000.
4. Grant stall. WRITE_RAM with VRAM_GNT held low for 10 cycles. Required: no VRAM_WE and ACK=0 throughout; VRAM_WE issues 1 cycle after GNT rises, and ACK rises 1 cycle after that.
5. Simultaneous requests. OP_SET_RAM_PTR and OP_WRITE_RAM both high, DIN=0x0010. Required: only the pointer is loaded (RAM_PTR=0x0010) and no VRAM_WE.
6. Reset mid-read. Assert RESET96n low while in RDWAIT. Required: all outputs return to 0 immediately; after release with no requests, no strobes and ACK stays 0.

Source files
------------

// File: rtl/gp9001_pkg.sv
// +----------------------------------------------------------------------+
// | gp9001_pkg: shared types and priority decode for the GP9001 host IF   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package gp9001_pkg;

  localparam int GP9001_REG_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAMWAIT = 2'd1,
    RDWAIT  = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_PTR  = 3'd1,
    OP_SEL  = 3'd2,
    OP_WREG = 3'd3,
    OP_WRAM = 3'd4,
    OP_RD   = 3'd5
  } op_t;

  // Both read flavours collapse to OP_RD: the hardware treats them identically.
  function automatic op_t prio_op(input logic set_ptr, input logic sel_reg,
                                  input logic wr_reg, input logic wr_ram,
                                  input logic rd_h, input logic rd_l);
    op_t op;
    op = OP_NONE;
    if (set_ptr)            op = OP_PTR;
    else if (sel_reg)       op = OP_SEL;
    else if (wr_reg)        op = OP_WREG;
    else if (wr_ram)        op = OP_WRAM;
    else if (rd_h || rd_l)  op = OP_RD;
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gp9001_host_if.sv
// +----------------------------------------------------------------------+
// | gp9001_host_if: 68k command responder driving VRAM host port / regs   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module gp9001_host_if
  import gp9001_pkg::*;
#(
  parameter int AW    = 14,
  parameter int RDLAT = 1
) (
  input  logic                    CLK96,
  input  logic                    RESET96n,
  input  logic                    OP_SELECT_REG,
  input  logic                    OP_WRITE_REG,
  input  logic                    OP_WRITE_RAM,
  input  logic                    OP_READ_RAM_H,
  input  logic                    OP_READ_RAM_L,
  input  logic                    OP_SET_RAM_PTR,
  input  logic [15:0]             DIN,
  output logic                    ACK,
  output logic [15:0]             DOUT,
  output logic [AW-1:0]           VRAM_ADDR,
  output logic [15:0]             VRAM_DIN,
  output logic                    VRAM_WE,
  output logic                    VRAM_RD,
  input  logic [15:0]             VRAM_Q,
  input  logic                    VRAM_GNT,
  output logic                    REG_WE,
  output logic [GP9001_REG_W-1:0] REG_ADDR,
  output logic [15:0]             REG_DATA,
  output logic [AW-1:0]           RAM_PTR
);

  state_t     state;
  op_t        req_op;
  logic       any_op;
  logic       ram_wr;
  logic [1:0] rd_cnt;

  assign req_op = prio_op(OP_SET_RAM_PTR, OP_SELECT_REG, OP_WRITE_REG,
                          OP_WRITE_RAM, OP_READ_RAM_H, OP_READ_RAM_L);
  assign any_op = OP_SET_RAM_PTR | OP_SELECT_REG | OP_WRITE_REG |
                  OP_WRITE_RAM | OP_READ_RAM_H | OP_READ_RAM_L;

  always_ff @(posedge CLK96 or negedge RESET96n) begin
    if (!RESET96n) begin
      state     <= IDLE;
      ram_wr    <= 1'b0;
      rd_cnt    <= 2'd0;
      ACK       <= 1'b0;
      DOUT      <= 16'h0000;
      VRAM_ADDR <= '0;
      VRAM_DIN  <= 16'h0000;
      VRAM_WE   <= 1'b0;
      VRAM_RD   <= 1'b0;
      REG_WE    <= 1'b0;
      REG_ADDR  <= '0;
      REG_DATA  <= 16'h0000;
      RAM_PTR   <= '0;
    end else begin
      VRAM_WE <= 1'b0;
      VRAM_RD <= 1'b0;
      REG_WE  <= 1'b0;
      case (state)
        IDLE: begin
          case (req_op)
            OP_PTR: begin
              RAM_PTR <= DIN[AW-1:0];
              state   <= DONE;
            end
            OP_SEL: begin
              REG_ADDR <= DIN[GP9001_REG_W-1:0];
              state    <= DONE;
            end
            OP_WREG: begin
              REG_DATA <= DIN;
              REG_WE   <= 1'b1;
              state    <= DONE;
            end
            OP_WRAM: begin
              ram_wr <= 1'b1;
              state  <= RAMWAIT;
            end
            OP_RD: begin
              ram_wr <= 1'b0;
              state  <= RAMWAIT;
            end
            default: state <= IDLE;
          endcase
        end
        // Grant is only consulted here; once a read is issued it runs to completion.
        RAMWAIT: begin
          if (VRAM_GNT) begin
            VRAM_ADDR <= RAM_PTR;
            if (ram_wr) begin
              VRAM_DIN <= DIN;
              VRAM_WE  <= 1'b1;
              RAM_PTR  <= RAM_PTR + AW'(1);
              state    <= DONE;
            end else begin
              VRAM_RD <= 1'b1;
              rd_cnt  <= 2'd0;
              state   <= RDWAIT;
            end
          end
        end
        RDWAIT: begin
          if (rd_cnt == 2'(RDLAT - 1)) begin
            DOUT    <= VRAM_Q;
            RAM_PTR <= RAM_PTR + AW'(1);
            state   <= DONE;
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end
        DONE: begin
          if (any_op) begin
            ACK <= 1'b1;
          end else begin
            ACK   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
